spi_wr_dma: RTL and testbench

//  Host-to-chip DMA: mirror of the SPI read-path DMA. The host writes a transfer of dma_depth

---
 rtl/spi_wr_dma.sv | 244 ++++++++++++++++++++++++
 tb/tb_spi_wr_dma.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_wr_dma.sv
// -----------------------------------------------------------------------------
// spi_wr_dma
//   Host-to-chip DMA for the SPI write path. The host pushes a transfer of
//   dma_depth bytes in blocks of BLK_SIZE = 2^BLK_WID bytes. Each block is
//   requested with a one-cycle dma_int pulse once the FIFO has room for a full
//   block. Bytes are buffered in a 2^BUF_WID-byte FIFO and handed to the
//   downstream consumer with a ready-gated strobe.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   dma_start    1-cycle pulse: start or restart a transfer
//   dma_depth    total transfer length in bytes, sampled on dma_start
//   spi_wr_ena   1-cycle strobe: spi_din carries a host byte
//   spi_din      host byte
//   out_rdy      downstream can take a byte this cycle
//   dma_en_out   1-cycle strobe: dma_dout valid
//   dma_dout     byte to downstream (holds last value between strobes)
//   dma_int      1-cycle pulse: host may write the next block
//   dma_done     1-cycle pulse: every requested byte has been delivered
//   ovf_err      sticky flag: a host write was dropped (cleared by dma_start)
// -----------------------------------------------------------------------------
module spi_wr_dma #(
   parameter int BUF_WID = 11,
   parameter int BLK_WID = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        dma_start,
   input  logic [16:0] dma_depth,
   input  logic        spi_wr_ena,
   input  logic [7:0]  spi_din,
   input  logic        out_rdy,
   output logic        dma_en_out,
   output logic [7:0]  dma_dout,
   output logic        dma_int,
   output logic        dma_done,
   output logic        ovf_err
);

   localparam logic [BUF_WID:0] C_FIFO_DEPTH = (BUF_WID+1)'(1 << BUF_WID);
   localparam logic [BUF_WID:0] C_BLK_FREE   = (BUF_WID+1)'(1 << BLK_WID);
   localparam logic [16:0]      C_BLK_REQ    = 17'(1 << BLK_WID);
   localparam logic [BLK_WID:0] C_BLK_LEN    = (BLK_WID+1)'(1 << BLK_WID);
   localparam logic [BUF_WID:0] C_PTR_ONE    = (BUF_WID+1)'(1);
   localparam logic [BLK_WID:0] C_BLK_ONE    = (BLK_WID+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_FILL  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // FIFO storage and pointers (one extra pointer bit separates full from empty)
   logic [7:0]       r_mem [0:(1<<BUF_WID)-1];
   logic [BUF_WID:0] r_wr_ptr;
   logic [BUF_WID:0] r_rd_ptr;

   // Transfer bookkeeping
   logic [16:0]      r_req_rem;
   logic [16:0]      r_depth;
   logic [16:0]      r_out_cnt;
   logic [BLK_WID:0] r_blk_len;
   logic [BLK_WID:0] r_blk_cnt;

   // Registered outputs
   logic             r_en_out;
   logic [7:0]       r_dout;
   logic             r_int;
   logic             r_done;
   logic             r_ovf;

   // Combinational helpers
   logic [BUF_WID:0] w_count;
   logic [BUF_WID:0] w_free;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [BLK_WID:0] w_blk_cnt_inc;
   logic [BLK_WID:0] w_blk_len_nxt;
   logic             w_int_nxt;
   logic             w_done_nxt;
   logic             w_blk_load;
   logic             w_blk_end;

   assign w_count       = r_wr_ptr - r_rd_ptr;
   assign w_free        = C_FIFO_DEPTH - w_count;
   assign w_full        = (w_count == C_FIFO_DEPTH);
   assign w_empty       = (w_count == '0);
   assign w_blk_cnt_inc = r_blk_cnt + C_BLK_ONE;

   // The final block of a transfer carries only the remainder.
   assign w_blk_len_nxt = (r_req_rem >= C_BLK_REQ) ? C_BLK_LEN : r_req_rem[BLK_WID:0];

   // dma_start wins over any write or pop issued in the same cycle.
   assign w_push = spi_wr_ena & ~dma_start & (r_state == S_FILL) & ~w_full &
                   (r_blk_cnt < r_blk_len);
   assign w_pop  = ~dma_start & ~w_empty & out_rdy & (r_state != S_IDLE);

   // -------------------------------------------------------------------------
   // FSM state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // FSM next-state and control decode
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_int_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
      w_blk_load  = 1'b0;
      w_blk_end   = 1'b0;

      if (dma_start) begin
         // A start in any state behaves like a start from IDLE.
         if (dma_depth != '0) begin
            w_state_nxt = S_CHECK;
         end else begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state_nxt = S_IDLE;
            end
            S_CHECK: begin
               if (r_req_rem == '0) begin
                  w_state_nxt = S_DRAIN;
               end else if (w_free >= C_BLK_FREE) begin
                  w_blk_load  = 1'b1;
                  w_int_nxt   = 1'b1;
                  w_state_nxt = S_FILL;
               end
            end
            S_FILL: begin
               // Leave on the write that completes the block so the next
               // request (or the drain phase) follows without a dead cycle.
               if (w_push && (w_blk_cnt_inc == r_blk_len)) begin
                  w_blk_end   = 1'b1;
                  w_state_nxt = S_CHECK;
               end
            end
            S_DRAIN: begin
               if (r_out_cnt == r_depth) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // FIFO storage: no reset, contents are don't-care until written
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[BUF_WID-1:0]] <= spi_din;
      end
   end

   // -------------------------------------------------------------------------
   // Pointers, counters, block tracking and registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_req_rem <= '0;
         r_depth   <= '0;
         r_out_cnt <= '0;
         r_blk_len <= '0;
         r_blk_cnt <= '0;
         r_en_out  <= 1'b0;
         r_dout    <= '0;
         r_int     <= 1'b0;
         r_done    <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_int    <= w_int_nxt;
         r_done   <= w_done_nxt;
         r_en_out <= w_pop;

         if (w_pop) begin
            r_dout <= r_mem[r_rd_ptr[BUF_WID-1:0]];
         end

         if (dma_start) begin
            // Flush and re-arm; any byte still in the FIFO is discarded.
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_req_rem <= dma_depth;
            r_depth   <= dma_depth;
            r_out_cnt <= '0;
            r_blk_len <= '0;
            r_blk_cnt <= '0;
            r_ovf     <= 1'b0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
               r_rd_ptr  <= r_rd_ptr + C_PTR_ONE;
               r_out_cnt <= r_out_cnt + 17'd1;
            end
            if (w_blk_load) begin
               r_blk_len <= w_blk_len_nxt;
               r_blk_cnt <= '0;
            end else if (w_push) begin
               r_blk_cnt <= w_blk_cnt_inc;
            end
            if (w_blk_end) begin
               r_req_rem <= r_req_rem - 17'(r_blk_len);
            end
            if (spi_wr_ena && !w_push) begin
               r_ovf <= 1'b1;
            end
         end
      end
   end

   assign dma_en_out = r_en_out;
   assign dma_dout   = r_dout;
   assign dma_int    = r_int;
   assign dma_done   = r_done;
   assign ovf_err    = r_ovf;

endmodule

// File: tb/tb_spi_wr_dma.sv
// -----------------------------------------------------------------------------
// tb_spi_wr_dma
//   Directed bench for spi_wr_dma. A background host answers every dma_int
//   with a block of pattern bytes; a background monitor records strobes,
//   interrupts and done pulses. Each test task drives one scenario and checks
//   the recorded activity against hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_spi_wr_dma;

   logic        clk        = 1'b0;
   logic        reset_n    = 1'b0;
   logic        dma_start  = 1'b0;
   logic [16:0] dma_depth  = '0;
   logic        spi_wr_ena;
   logic [7:0]  spi_din;
   logic        out_rdy    = 1'b0;
   logic        dma_en_out;
   logic [7:0]  dma_dout;
   logic        dma_int;
   logic        dma_done;
   logic        ovf_err;

   always #5 clk = ~clk;

   spi_wr_dma dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .dma_start  (dma_start),
      .dma_depth  (dma_depth),
      .spi_wr_ena (spi_wr_ena),
      .spi_din    (spi_din),
      .out_rdy    (out_rdy),
      .dma_en_out (dma_en_out),
      .dma_dout   (dma_dout),
      .dma_int    (dma_int),
      .dma_done   (dma_done),
      .ovf_err    (ovf_err)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // monitor state
   int         n_int           = 0;
   int         n_done          = 0;
   int         cyc             = 0;
   int         done_cyc        = 0;
   int         last_strobe_cyc = 0;
   logic [7:0] got_q [$];

   // host state
   int host_depth = 0;
   int host_req   = 0;
   int host_blk   = 0;
   int host_extra = 0;
   int host_sent  = 0;
   int blk_q [$];

   function automatic logic [7:0] pat(input int i);
      return 8'(i * 37 + 11);
   endfunction

   // Host: every dma_int grants min(1024, remaining) bytes (+ optional extra).
   initial begin : host
      int b;
      spi_wr_ena = 1'b0;
      spi_din    = 8'h00;
      forever begin
         @(negedge clk);
         if (dma_int === 1'b1) begin
            b = host_depth - host_req;
            if (b > 1024) b = 1024;
            host_req += b;
            blk_q.push_back(b);
            host_blk += b + host_extra;
            host_extra = 0;
         end
         @(posedge clk);
         #1;
         if (host_blk > 0) begin
            spi_wr_ena = 1'b1;
            spi_din    = pat(host_sent);
            host_sent++;
            host_blk--;
         end else begin
            spi_wr_ena = 1'b0;
         end
      end
   end

   // Monitor: sampled on the falling edge.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (dma_int === 1'b1) n_int++;
         if (dma_done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
         end
         if (dma_en_out === 1'b1) begin
            got_q.push_back(dma_dout);
            last_strobe_cyc = cyc;
         end
         cyc++;
      end
   end

   initial begin : watchdog
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called right at a rising edge, away from the host/monitor sample points.
   task automatic clear_all(input int depth, input int sent_base, input int extra);
      n_int = 0;
      n_done = 0;
      got_q.delete();
      blk_q.delete();
      host_depth = depth;
      host_req   = 0;
      host_blk   = 0;
      host_extra = extra;
      host_sent  = sent_base;
   endtask

   task automatic start_dma(input int depth);
      @(posedge clk);
      #1;
      dma_start = 1'b1;
      dma_depth = 17'(depth);
      @(posedge clk);
      #1;
      dma_start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int g;
      g = 0;
      while (n_done == 0 && g < budget) begin
         @(posedge clk);
         g++;
      end
      repeat (8) @(posedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests_run++; if (dma_en_out !== 1'b0) begin tests_failed++; $display("FAIL reset_en_out: got %b want 0", dma_en_out); end
      tests_run++; if (dma_dout !== 8'h00) begin tests_failed++; $display("FAIL reset_dout: got %h want 00", dma_dout); end
      tests_run++; if (dma_int !== 1'b0) begin tests_failed++; $display("FAIL reset_int: got %b want 0", dma_int); end
      tests_run++; if (dma_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", dma_done); end
      tests_run++; if (ovf_err !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b want 0", ovf_err); end
      reset_n = 1'b1;
      @(posedge clk);
      clear_all(0, 0, 0);
      repeat (5) @(posedge clk);
      tests_run++; if (n_int !== 0) begin tests_failed++; $display("FAIL idle_no_int: got %0d want 0", n_int); end
   endtask

   task automatic test_full_transfer();
      int errs;
      logic blk_ok;
      @(posedge clk);
      clear_all(3000, 0, 0);
      out_rdy = 1'b1;
      start_dma(3000);
      wait_done(20000);
      tests_run++; if (n_done !== 1) begin tests_failed++; $display("FAIL t1_done_count: got %0d want 1", n_done); end
      tests_run++; if (n_int !== 3) begin tests_failed++; $display("FAIL t1_int_count: got %0d want 3", n_int); end
      blk_ok = (blk_q.size() == 3);
      if (blk_ok) blk_ok = (blk_q[0] == 1024) && (blk_q[1] == 1024) && (blk_q[2] == 952);
      tests_run++; if (blk_ok !== 1'b1) begin tests_failed++; $display("FAIL t1_blocks: got %0d blocks want 1024,1024,952", blk_q.size()); end
      tests_run++; if (got_q.size() !== 3000) begin tests_failed++; $display("FAIL t1_strobes: got %0d want 3000", got_q.size()); end
      errs = 0;
      foreach (got_q[k]) if (got_q[k] !== pat(k)) errs++;
      tests_run++; if (errs !== 0) begin tests_failed++; $display("FAIL t1_data: %0d bytes wrong, want 0", errs); end
      tests_run++; if (done_cyc - last_strobe_cyc !== 1) begin tests_failed++; $display("FAIL t1_done_lat: got %0d want 1", done_cyc - last_strobe_cyc); end
      tests_run++; if (ovf_err !== 1'b0) begin tests_failed++; $display("FAIL t1_ovf: got %b want 0", ovf_err); end
   endtask

   task automatic test_backpressure();
      int g;
      int errs;
      @(posedge clk);
      clear_all(4096, 0, 0);
      out_rdy = 1'b0;
      start_dma(4096);
      g = 0;
      while (host_sent < 2048 && g < 5000) begin
         @(posedge clk);
         g++;
      end
      repeat (60) @(posedge clk);
      tests_run++; if (n_int !== 2) begin tests_failed++; $display("FAIL t2_int_full: got %0d want 2", n_int); end
      tests_run++; if (got_q.size() !== 0) begin tests_failed++; $display("FAIL t2_no_out: got %0d want 0", got_q.size()); end
      tests_run++; if (host_sent !== 2048) begin tests_failed++; $display("FAIL t2_written: got %0d want 2048", host_sent); end
      #1;
      out_rdy = 1'b1;
      g = 0;
      while (n_int < 3 && g < 3000) begin
         @(posedge clk);
         g++;
      end
      // 1024 pops free a block; the request appears while pop 1025 is in flight.
      tests_run++; if (got_q.size() !== 1025) begin tests_failed++; $display("FAIL t2_int3_point: got %0d strobes want 1025", got_q.size()); end
      wait_done(12000);
      tests_run++; if (n_done !== 1) begin tests_failed++; $display("FAIL t2_done_count: got %0d want 1", n_done); end
      tests_run++; if (n_int !== 4) begin tests_failed++; $display("FAIL t2_int_count: got %0d want 4", n_int); end
      tests_run++; if (got_q.size() !== 4096) begin tests_failed++; $display("FAIL t2_strobes: got %0d want 4096", got_q.size()); end
      errs = 0;
      foreach (got_q[k]) if (got_q[k] !== pat(k)) errs++;
      tests_run++; if (errs !== 0) begin tests_failed++; $display("FAIL t2_data: %0d bytes wrong, want 0", errs); end
   endtask

   task automatic test_overflow();
      int errs;
      @(posedge clk);
      clear_all(1024, 0, 1);
      out_rdy = 1'b1;
      start_dma(1024);
      wait_done(5000);
      tests_run++; if (host_sent !== 1025) begin tests_failed++; $display("FAIL t3_written: got %0d want 1025", host_sent); end
      tests_run++; if (ovf_err !== 1'b1) begin tests_failed++; $display("FAIL t3_ovf_set: got %b want 1", ovf_err); end
      tests_run++; if (n_int !== 1) begin tests_failed++; $display("FAIL t3_int_count: got %0d want 1", n_int); end
      tests_run++; if (got_q.size() !== 1024) begin tests_failed++; $display("FAIL t3_strobes: got %0d want 1024", got_q.size()); end
      errs = 0;
      foreach (got_q[k]) if (got_q[k] !== pat(k)) errs++;
      tests_run++; if (errs !== 0) begin tests_failed++; $display("FAIL t3_data: %0d bytes wrong, want 0", errs); end
      repeat (20) @(posedge clk);
      tests_run++; if (ovf_err !== 1'b1) begin tests_failed++; $display("FAIL t3_ovf_sticky: got %b want 1", ovf_err); end
   endtask

   task automatic test_small_block();
      int errs;
      @(posedge clk);
      clear_all(5, 0, 0);
      out_rdy = 1'b1;
      start_dma(5);
      @(negedge clk);
      tests_run++; if (ovf_err !== 1'b0) begin tests_failed++; $display("FAIL t4_ovf_clear: got %b want 0", ovf_err); end
      wait_done(500);
      tests_run++; if (n_int !== 1) begin tests_failed++; $display("FAIL t4_int_count: got %0d want 1", n_int); end
      tests_run++; if (blk_q.size() !== 1 || blk_q[0] !== 5) begin tests_failed++; $display("FAIL t4_blk_len: got %0d blocks want one of 5", blk_q.size()); end
      tests_run++; if (got_q.size() !== 5) begin tests_failed++; $display("FAIL t4_strobes: got %0d want 5", got_q.size()); end
      errs = 0;
      foreach (got_q[k]) if (got_q[k] !== pat(k)) errs++;
      tests_run++; if (errs !== 0) begin tests_failed++; $display("FAIL t4_data: %0d bytes wrong, want 0", errs); end
      tests_run++; if (n_done !== 1) begin tests_failed++; $display("FAIL t4_done_count: got %0d want 1", n_done); end
      tests_run++; if (done_cyc - last_strobe_cyc !== 1) begin tests_failed++; $display("FAIL t4_done_lat: got %0d want 1", done_cyc - last_strobe_cyc); end
   endtask

   task automatic test_abort();
      int g;
      int errs;
      @(posedge clk);
      clear_all(10, 0, 0);
      out_rdy = 1'b0;
      start_dma(10);
      g = 0;
      while (host_sent < 4 && g < 200) begin
         @(negedge clk);
         g++;
      end
      // Stop the old block at the edge, then restart with a fresh pattern.
      @(posedge clk);
      host_blk   = 0;
      host_req   = 0;
      host_sent  = 100;
      host_depth = 10;
      #1;
      dma_start = 1'b1;
      dma_depth = 17'd10;
      out_rdy   = 1'b1;
      @(posedge clk);
      #1;
      dma_start = 1'b0;
      wait_done(500);
      tests_run++; if (n_int !== 2) begin tests_failed++; $display("FAIL t5_int_count: got %0d want 2", n_int); end
      tests_run++; if (got_q.size() !== 10) begin tests_failed++; $display("FAIL t5_strobes: got %0d want 10", got_q.size()); end
      errs = 0;
      foreach (got_q[k]) if (got_q[k] !== pat(100 + k)) errs++;
      tests_run++; if (errs !== 0) begin tests_failed++; $display("FAIL t5_data: %0d bytes wrong, want 0", errs); end
      tests_run++; if (n_done !== 1) begin tests_failed++; $display("FAIL t5_done_count: got %0d want 1", n_done); end
      tests_run++; if (ovf_err !== 1'b0) begin tests_failed++; $display("FAIL t5_ovf: got %b want 0", ovf_err); end
   endtask

   task automatic test_reset_mid_drain();
      int g;
      int start_cyc;
      @(posedge clk);
      clear_all(5, 0, 0);
      out_rdy = 1'b0;
      start_dma(5);
      g = 0;
      while (host_sent < 5 && g < 200) begin
         @(posedge clk);
         g++;
      end
      repeat (6) @(posedge clk);
      #1;
      out_rdy = 1'b1;
      g = 0;
      while (got_q.size() < 2 && g < 50) begin
         @(posedge clk);
         g++;
      end
      #3;
      tests_run++; if (dma_en_out !== 1'b1) begin tests_failed++; $display("FAIL t6_pre_strobe: got %b want 1", dma_en_out); end
      reset_n = 1'b0;
      #1;
      tests_run++; if (dma_en_out !== 1'b0) begin tests_failed++; $display("FAIL t6_rst_en_out: got %b want 0", dma_en_out); end
      tests_run++; if (dma_dout !== 8'h00) begin tests_failed++; $display("FAIL t6_rst_dout: got %h want 00", dma_dout); end
      tests_run++; if (dma_int !== 1'b0) begin tests_failed++; $display("FAIL t6_rst_int: got %b want 0", dma_int); end
      tests_run++; if (dma_done !== 1'b0) begin tests_failed++; $display("FAIL t6_rst_done: got %b want 0", dma_done); end
      tests_run++; if (ovf_err !== 1'b0) begin tests_failed++; $display("FAIL t6_rst_ovf: got %b want 0", ovf_err); end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      clear_all(0, 0, 0);
      repeat (10) @(posedge clk);
      tests_run++; if (n_done !== 0) begin tests_failed++; $display("FAIL t6_no_done: got %0d want 0", n_done); end
      tests_run++; if (got_q.size() !== 0) begin tests_failed++; $display("FAIL t6_idle_no_out: got %0d want 0", got_q.size()); end
      @(posedge clk);
      #1;
      dma_start = 1'b1;
      dma_depth = 17'd0;
      start_cyc = cyc;
      @(posedge clk);
      #1;
      dma_start = 1'b0;
      repeat (10) @(posedge clk);
      tests_run++; if (n_done !== 1) begin tests_failed++; $display("FAIL t6_zero_done: got %0d want 1", n_done); end
      tests_run++; if (done_cyc - start_cyc !== 1) begin tests_failed++; $display("FAIL t6_zero_done_lat: got %0d want 1", done_cyc - start_cyc); end
      tests_run++; if (n_int !== 0) begin tests_failed++; $display("FAIL t6_zero_int: got %0d want 0", n_int); end
      tests_run++; if (got_q.size() !== 0) begin tests_failed++; $display("FAIL t6_zero_out: got %0d want 0", got_q.size()); end
   endtask

   initial begin : main
      test_reset();
      test_full_transfer();
      test_backpressure();
      test_overflow();
      test_small_block();
      test_abort();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
